// File: rtl/axi_arb_pkg.sv
// Shared state encoding and AXI width constants for the 2:1 AXI arbiter.
package axi_arb_pkg;

    localparam int AXI_ADDR_W = 40;
    localparam int AXI_ID_W   = 8;
    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } arb_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin picker: on a tie the master that did not win last time is chosen.
module axi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       gnt_vld
);

    // Pure combinational pick; the caller registers the winner.
    always_comb begin
        gnt_vld = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/axi_arb2to1_128.sv
// Two-master to one-slave AXI arbiter, one whole burst in flight at a time.
// Routing is purely combinational from the registered state and grant.
//
//  state   | meaning
//  IDLE    | no owner; arbitrate between pending AR/AW requests
//  AR      | forward granted master's read address
//  R       | forward read data back until the rlast handshake
//  AW      | forward granted master's write address
//  W       | forward write data until the wlast handshake
//  B       | forward write response until its handshake
module axi_arb2to1_128
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int ID_W   = AXI_ID_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst,
    // master 0
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [1:0]        m0_arburst,
    input  logic [3:0]        m0_arcache,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arprot,
    input  logic [2:0]        m0_arsize,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [1:0]        m0_awburst,
    input  logic [3:0]        m0_awcache,
    input  logic [ID_W-1:0]   m0_awid,
    input  logic [7:0]        m0_awlen,
    input  logic [2:0]        m0_awprot,
    input  logic [2:0]        m0_awsize,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [ID_W-1:0]   m0_wid,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [ID_W-1:0]   m0_bid,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    // master 1
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [1:0]        m1_arburst,
    input  logic [3:0]        m1_arcache,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arprot,
    input  logic [2:0]        m1_arsize,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [1:0]        m1_awburst,
    input  logic [3:0]        m1_awcache,
    input  logic [ID_W-1:0]   m1_awid,
    input  logic [7:0]        m1_awlen,
    input  logic [2:0]        m1_awprot,
    input  logic [2:0]        m1_awsize,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [ID_W-1:0]   m1_wid,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [ID_W-1:0]   m1_bid,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    // slave
    output logic [ADDR_W-1:0] s_araddr,
    output logic [1:0]        s_arburst,
    output logic [3:0]        s_arcache,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arprot,
    output logic [2:0]        s_arsize,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [1:0]        s_awburst,
    output logic [3:0]        s_awcache,
    output logic [ID_W-1:0]   s_awid,
    output logic [7:0]        s_awlen,
    output logic [2:0]        s_awprot,
    output logic [2:0]        s_awsize,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic [ID_W-1:0]   s_wid,
    output logic              s_wlast,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [ID_W-1:0]   s_bid,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    // status
    output logic              grant_id,
    output logic              busy
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       pick, pick_vld;
    logic       sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_wlast, sel_bready;

    axi_rr_arb2 u_rr (
        .req        ({m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid}),
        .last_grant (last_grant_q),
        .grant      (pick),
        .gnt_vld    (pick_vld)
    );

    assign sel_arvalid = grant_q ? m1_arvalid : m0_arvalid;
    assign sel_rready  = grant_q ? m1_rready  : m0_rready;
    assign sel_awvalid = grant_q ? m1_awvalid : m0_awvalid;
    assign sel_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
    assign sel_wlast   = grant_q ? m1_wlast   : m0_wlast;
    assign sel_bready  = grant_q ? m1_bready  : m0_bready;

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

    // State, owner and round-robin history registers.
    always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: arbitrate in IDLE (read preferred), then follow the burst handshakes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: if (pick_vld) begin
                grant_d      = pick;
                last_grant_d = pick;
                state_d      = (pick ? m1_arvalid : m0_arvalid) ? ST_AR : ST_AW;
            end
            ST_AR:   if (sel_arvalid && s_arready)           state_d = ST_R;
            ST_R:    if (s_rvalid && sel_rready && s_rlast)  state_d = ST_IDLE;
            ST_AW:   if (sel_awvalid && s_awready)           state_d = ST_W;
            ST_W:    if (sel_wvalid && s_wready && sel_wlast) state_d = ST_B;
            ST_B:    if (s_bvalid && sel_bready)             state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel routing: only the channel owned by the current state is connected.
    always_comb begin
        s_araddr = '0; s_arburst = '0; s_arcache = '0; s_arid = '0;
        s_arlen = '0; s_arprot = '0; s_arsize = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        s_awaddr = '0; s_awburst = '0; s_awcache = '0; s_awid = '0;
        s_awlen = '0; s_awprot = '0; s_awsize = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wid = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        m0_arready = 1'b0; m1_arready = 1'b0;
        m0_awready = 1'b0; m1_awready = 1'b0;
        m0_wready = 1'b0;  m1_wready = 1'b0;
        m0_rdata = '0; m0_rid = '0; m0_rresp = '0; m0_rlast = 1'b0; m0_rvalid = 1'b0;
        m1_rdata = '0; m1_rid = '0; m1_rresp = '0; m1_rlast = 1'b0; m1_rvalid = 1'b0;
        m0_bid = '0; m0_bresp = '0; m0_bvalid = 1'b0;
        m1_bid = '0; m1_bresp = '0; m1_bvalid = 1'b0;
        case (state_q)
            ST_AR: begin
                s_araddr  = grant_q ? m1_araddr  : m0_araddr;
                s_arburst = grant_q ? m1_arburst : m0_arburst;
                s_arcache = grant_q ? m1_arcache : m0_arcache;
                s_arid    = grant_q ? m1_arid    : m0_arid;
                s_arlen   = grant_q ? m1_arlen   : m0_arlen;
                s_arprot  = grant_q ? m1_arprot  : m0_arprot;
                s_arsize  = grant_q ? m1_arsize  : m0_arsize;
                s_arvalid = sel_arvalid;
                m0_arready = ~grant_q & s_arready;
                m1_arready =  grant_q & s_arready;
            end
            ST_R: begin
                s_rready = sel_rready;
                if (grant_q) begin
                    m1_rdata = s_rdata; m1_rid = s_rid; m1_rresp = s_rresp;
                    m1_rlast = s_rlast; m1_rvalid = s_rvalid;
                end else begin
                    m0_rdata = s_rdata; m0_rid = s_rid; m0_rresp = s_rresp;
                    m0_rlast = s_rlast; m0_rvalid = s_rvalid;
                end
            end
            ST_AW: begin
                s_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
                s_awburst = grant_q ? m1_awburst : m0_awburst;
                s_awcache = grant_q ? m1_awcache : m0_awcache;
                s_awid    = grant_q ? m1_awid    : m0_awid;
                s_awlen   = grant_q ? m1_awlen   : m0_awlen;
                s_awprot  = grant_q ? m1_awprot  : m0_awprot;
                s_awsize  = grant_q ? m1_awsize  : m0_awsize;
                s_awvalid = sel_awvalid;
                m0_awready = ~grant_q & s_awready;
                m1_awready =  grant_q & s_awready;
            end
            ST_W: begin
                s_wdata  = grant_q ? m1_wdata : m0_wdata;
                s_wstrb  = grant_q ? m1_wstrb : m0_wstrb;
                s_wid    = grant_q ? m1_wid   : m0_wid;
                s_wlast  = sel_wlast;
                s_wvalid = sel_wvalid;
                m0_wready = ~grant_q & s_wready;
                m1_wready =  grant_q & s_wready;
            end
            ST_B: begin
                s_bready = sel_bready;
                if (grant_q) begin
                    m1_bid = s_bid; m1_bresp = s_bresp; m1_bvalid = s_bvalid;
                end else begin
                    m0_bid = s_bid; m0_bresp = s_bresp; m0_bvalid = s_bvalid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arb2to1_128.sv
// Self-checking bench for the 2:1 AXI arbiter with a queue-based scoreboard.
module tb_axi_arb2to1_128;
    import axi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // master-side signals, index = master number
    logic [1:0][AXI_ADDR_W-1:0] araddr, awaddr;
    logic [1:0][1:0]            arburst, awburst, rresp, bresp;
    logic [1:0][3:0]            arcache, awcache;
    logic [1:0][AXI_ID_W-1:0]   arid, awid, rid, wid, bid;
    logic [1:0][7:0]            arlen, awlen;
    logic [1:0][2:0]            arprot, arsize, awprot, awsize;
    logic [1:0][AXI_DATA_W-1:0] rdata, wdata;
    logic [1:0][AXI_STRB_W-1:0] wstrb;
    logic [1:0] arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic [1:0] wlast, wvalid, wready, bvalid, bready;
    // slave side
    logic [AXI_ADDR_W-1:0] s_araddr, s_awaddr;
    logic [1:0]            s_arburst, s_awburst, s_rresp, s_bresp;
    logic [3:0]            s_arcache, s_awcache;
    logic [AXI_ID_W-1:0]   s_arid, s_awid, s_rid, s_wid, s_bid;
    logic [7:0]            s_arlen, s_awlen;
    logic [2:0]            s_arprot, s_arsize, s_awprot, s_awsize;
    logic [AXI_DATA_W-1:0] s_rdata, s_wdata;
    logic [AXI_STRB_W-1:0] s_wstrb;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic grant_id, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic                  exp_grant_q[$];
    logic [AXI_DATA_W-1:0] exp_rdata_q[$];
    logic [AXI_DATA_W-1:0] exp_wdata_q[$];
    logic [AXI_ID_W-1:0]   exp_bid_q[$];

    axi_arb2to1_128 dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
        .m0_araddr(araddr[0]), .m0_arburst(arburst[0]), .m0_arcache(arcache[0]), .m0_arid(arid[0]),
        .m0_arlen(arlen[0]), .m0_arprot(arprot[0]), .m0_arsize(arsize[0]), .m0_arvalid(arvalid[0]),
        .m0_arready(arready[0]), .m0_rdata(rdata[0]), .m0_rid(rid[0]), .m0_rresp(rresp[0]),
        .m0_rlast(rlast[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m0_awaddr(awaddr[0]), .m0_awburst(awburst[0]), .m0_awcache(awcache[0]), .m0_awid(awid[0]),
        .m0_awlen(awlen[0]), .m0_awprot(awprot[0]), .m0_awsize(awsize[0]), .m0_awvalid(awvalid[0]),
        .m0_awready(awready[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wid(wid[0]),
        .m0_wlast(wlast[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
        .m0_bid(bid[0]), .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
        .m1_araddr(araddr[1]), .m1_arburst(arburst[1]), .m1_arcache(arcache[1]), .m1_arid(arid[1]),
        .m1_arlen(arlen[1]), .m1_arprot(arprot[1]), .m1_arsize(arsize[1]), .m1_arvalid(arvalid[1]),
        .m1_arready(arready[1]), .m1_rdata(rdata[1]), .m1_rid(rid[1]), .m1_rresp(rresp[1]),
        .m1_rlast(rlast[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .m1_awaddr(awaddr[1]), .m1_awburst(awburst[1]), .m1_awcache(awcache[1]), .m1_awid(awid[1]),
        .m1_awlen(awlen[1]), .m1_awprot(awprot[1]), .m1_awsize(awsize[1]), .m1_awvalid(awvalid[1]),
        .m1_awready(awready[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wid(wid[1]),
        .m1_wlast(wlast[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
        .m1_bid(bid[1]), .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
        .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arprot(s_arprot), .s_arsize(s_arsize), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awburst(s_awburst), .s_awcache(s_awcache), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awprot(s_awprot), .s_awsize(s_awsize), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wid(s_wid),
        .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        araddr = '0; arburst = '0; arcache = '0; arid = '0; arlen = '0; arprot = '0; arsize = '0;
        awaddr = '0; awburst = '0; awcache = '0; awid = '0; awlen = '0; awprot = '0; awsize = '0;
        arvalid = '0; rready = '0; awvalid = '0; bready = '0;
        wdata = '0; wstrb = '0; wid = '0; wlast = '0; wvalid = '0;
        s_arready = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        exp_grant_q.delete(); exp_rdata_q.delete(); exp_wdata_q.delete(); exp_bid_q.delete();
        cyc();
    endtask

    // Full read transaction for master m; assumes the DUT is idle on entry.
    task automatic run_read(input int m, input logic [39:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input bit toggle, input bit keep);
        int o = 1 - m;
        int n = 0;
        int beat = 0;
        bit ph = 1'b1;
        bit hs;
        logic eg;
        logic [AXI_DATA_W-1:0] d, e;
        araddr[m] = addr; arlen[m] = len; arid[m] = id; arvalid[m] = 1'b1; s_arready = 1'b1;
        #1;
        while (!busy && n < 20) begin cyc(); n++; end
        n_checks++;
        if (n !== 1) begin n_fail++; $display("FAIL rd_arb_latency: took %0d cycles, expected 1", n); end
        eg = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 1'bx;
        n_checks++;
        if (grant_id !== eg) begin n_fail++; $display("FAIL rd_grant_id: got %0b expected %0b", grant_id, eg); end
        n_checks++;
        if ({s_arvalid, s_araddr, s_arlen, s_arid} !== {1'b1, addr, len, id}) begin
            n_fail++;
            $display("FAIL rd_ar_fwd: valid=%0b addr=%h len=%0d id=%h expected 1 %h %0d %h",
                     s_arvalid, s_araddr, s_arlen, s_arid, addr, len, id);
        end
        n_checks++;
        if (arready !== 2'(1 << m)) begin n_fail++; $display("FAIL rd_arready: got %b expected %b", arready, 2'(1 << m)); end
        n_checks++;
        if ({s_awvalid, s_wvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_aw_isolation: awvalid=%0b wvalid=%0b expected 0 0", s_awvalid, s_wvalid); end
        cyc();
        if (!keep) arvalid[m] = 1'b0;
        s_arready = 1'b0;
        n = 0;
        while (beat <= int'(len) && n < 200) begin
            if (!s_rvalid) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                s_rdata = d; s_rid = id; s_rresp = 2'b00; s_rlast = (beat == int'(len)); s_rvalid = 1'b1;
                exp_rdata_q.push_back(d);
            end
            rready[m] = toggle ? ph : 1'b1;
            rready[o] = 1'b1;
            ph = ~ph;
            hs = 1'b0;
            #1;
            n_checks++;
            if (s_rready !== rready[m]) begin n_fail++; $display("FAIL rd_rready_mirror: got %0b expected %0b", s_rready, rready[m]); end
            n_checks++;
            if (rvalid[o] !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL rd_other_or_busy: other_rvalid=%0b busy=%0b expected 0 1", rvalid[o], busy);
            end
            if (rvalid[m] === 1'b1 && rready[m] === 1'b1) begin
                e = (exp_rdata_q.size() > 0) ? exp_rdata_q.pop_front() : 'x;
                n_checks++;
                if ({rdata[m], rlast[m], rid[m]} !== {e, beat == int'(len), id}) begin
                    n_fail++;
                    $display("FAIL rd_beat%0d: data=%h last=%0b id=%h expected %h %0b %h",
                             beat, rdata[m], rlast[m], rid[m], e, beat == int'(len), id);
                end
                beat++;
                hs = 1'b1;
            end
            cyc();
            if (hs) s_rvalid = 1'b0;
            n++;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; rready = '0;
        n_checks++;
        if (beat <= int'(len)) begin n_fail++; $display("FAIL rd_timeout: got %0d beats expected %0d", beat, int'(len) + 1); end
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_exit_idle: busy=%0b expected 0", busy); end
    endtask

    // Full write transaction for master m; a W beat is presented before the AW handshake.
    task automatic run_write(input int m, input logic [39:0] addr, input logic [7:0] len, input logic [7:0] id);
        int o = 1 - m;
        int n = 0;
        logic eg;
        logic [AXI_DATA_W-1:0] e;
        logic [AXI_ID_W-1:0] eb;
        awaddr[m] = addr; awlen[m] = len; awid[m] = id; awvalid[m] = 1'b1; s_awready = 1'b1;
        wdata[m] = {$urandom, $urandom, $urandom, $urandom}; wstrb[m] = '1; wid[m] = id;
        wlast[m] = (len == 8'd0); wvalid[m] = 1'b1; s_wready = 1'b1;
        exp_bid_q.push_back(id);
        #1;
        while (!busy && n < 20) begin cyc(); n++; end
        n_checks++;
        if (n !== 1) begin n_fail++; $display("FAIL wr_arb_latency: took %0d cycles, expected 1", n); end
        eg = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 1'bx;
        n_checks++;
        if (grant_id !== eg) begin n_fail++; $display("FAIL wr_grant_id: got %0b expected %0b", grant_id, eg); end
        n_checks++;
        if ({s_awvalid, s_awaddr, s_awlen, s_awid, awready} !== {1'b1, addr, len, id, 2'(1 << m)}) begin
            n_fail++;
            $display("FAIL wr_aw_fwd: valid=%0b addr=%h len=%0d id=%h awready=%b expected 1 %h %0d %h %b",
                     s_awvalid, s_awaddr, s_awlen, s_awid, awready, addr, len, id, 2'(1 << m));
        end
        n_checks++;
        if ({s_wvalid, wready} !== 3'b000) begin n_fail++; $display("FAIL wr_early_w: s_wvalid=%0b wready=%b expected 0 00", s_wvalid, wready); end
        cyc();
        awvalid[m] = 1'b0; s_awready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b > 0) wdata[m] = {$urandom, $urandom, $urandom, $urandom};
            wlast[m] = (b == int'(len));
            exp_wdata_q.push_back(wdata[m]);
            #1;
            n_checks++;
            if (s_wvalid !== 1'b1 || wready !== 2'(1 << m)) begin
                n_fail++; $display("FAIL wr_w_hs%0d: s_wvalid=%0b wready=%b expected 1 %b", b, s_wvalid, wready, 2'(1 << m));
            end
            e = exp_wdata_q.pop_front();
            n_checks++;
            if ({s_wdata, s_wlast, s_wid, s_wstrb} !== {e, b == int'(len), id, {AXI_STRB_W{1'b1}}}) begin
                n_fail++; $display("FAIL wr_w_beat%0d: data=%h last=%0b id=%h expected %h %0b %h", b, s_wdata, s_wlast, s_wid, e, b == int'(len), id);
            end
            cyc();
        end
        wvalid[m] = 1'b0; wlast[m] = 1'b0; s_wready = 1'b0;
        s_bid = id; s_bresp = 2'b00; s_bvalid = 1'b1; bready = 2'b11;
        #1;
        eb = (exp_bid_q.size() > 0) ? exp_bid_q.pop_front() : 'x;
        n_checks++;
        if ({bvalid[m], bid[m], bvalid[o], s_bready} !== {1'b1, eb, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wr_b_fwd: bvalid=%0b bid=%h other_bvalid=%0b s_bready=%0b expected 1 %h 0 1", bvalid[m], bid[m], bvalid[o], s_bready, eb);
        end
        cyc();
        s_bvalid = 1'b0; bready = '0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_exit_idle: busy=%0b expected 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        arvalid[0] = 1'b1; awvalid[1] = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if ({busy, grant_id} !== 2'b00) begin n_fail++; $display("FAIL reset_status: busy=%0b grant=%0b expected 0 0", busy, grant_id); end
        n_checks++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_slave_ctl: got %b expected 00000", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready});
        end
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 10'b0) begin
            n_fail++; $display("FAIL reset_master_ctl: got %b expected 0", {arready, awready, wready, rvalid, bvalid});
        end
        n_checks++;
        if ({s_araddr, s_awaddr, rdata[0], rdata[1]} !== '0) begin n_fail++; $display("FAIL reset_payload: nonzero payload, expected 0"); end
        clear_inputs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        exp_grant_q.push_back(1'b0);
        run_read(0, 40'h100, 8'd3, 8'h11, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        apply_reset();
        araddr[1] = 40'h2_0000_0040; arlen[1] = 8'd1; arid[1] = 8'h21; arvalid[1] = 1'b1;
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        run_read(0, 40'h200, 8'd1, 8'h20, 1'b0, 1'b0);
        run_read(1, 40'h2_0000_0040, 8'd1, 8'h21, 1'b0, 1'b0);
    endtask

    task automatic test_write();
        exp_grant_q.push_back(1'b1);
        run_write(1, 40'h300, 8'd1, 8'h5a);
    endtask

    task automatic test_backpressure();
        exp_grant_q.push_back(1'b0);
        run_read(0, 40'h400, 8'd3, 8'h33, 1'b1, 1'b0);
    endtask

    task automatic test_ar_before_aw();
        awaddr[0] = 40'h500; awlen[0] = 8'd0; awid[0] = 8'h44; awvalid[0] = 1'b1;
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b0);
        run_read(0, 40'h580, 8'd0, 8'h45, 1'b0, 1'b0);
        run_write(0, 40'h500, 8'd0, 8'h44);
    endtask

    task automatic test_starvation();
        apply_reset();
        araddr[1] = 40'h610; arlen[1] = 8'd0; arid[1] = 8'h61; arvalid[1] = 1'b1;
        for (int i = 0; i < 6; i++) exp_grant_q.push_back(i[0]);
        for (int i = 0; i < 6; i++) begin
            if (i[0]) run_read(1, 40'h610, 8'd0, 8'h61, 1'b0, 1'b1);
            else      run_read(0, 40'h600, 8'd0, 8'h60, 1'b0, 1'b1);
        end
        arvalid = '0;
        cyc();
    endtask

    task automatic test_reset_mid_w();
        int n = 0;
        awaddr[1] = 40'h700; awlen[1] = 8'd3; awid[1] = 8'h71; awvalid[1] = 1'b1; s_awready = 1'b1;
        wdata[1] = {4{32'hcafe_0001}}; wstrb[1] = '1; wid[1] = 8'h71; wlast[1] = 1'b0; wvalid[1] = 1'b1;
        s_wready = 1'b1;
        #1;
        while (!busy && n < 20) begin cyc(); n++; end
        n_checks++;
        if ({busy, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rst_w_grant: busy=%0b grant=%0b expected 1 1", busy, grant_id); end
        cyc();
        awvalid[1] = 1'b0;
        cyc();
        wdata[1] = {4{32'hcafe_0002}};
        #2;
        rst = 1'b1;
        cyc();
        n_checks++;
        if ({busy, grant_id, s_wvalid, wready, s_awvalid, s_bready, s_wdata} !== '0) begin
            n_fail++; $display("FAIL rst_w_outputs: busy=%0b grant=%0b s_wvalid=%0b wready=%b expected all 0", busy, grant_id, s_wvalid, wready);
        end
        clear_inputs();
        rst = 1'b0;
        cyc();
        exp_grant_q.push_back(1'b1);
        run_read(1, 40'h800, 8'd2, 8'h81, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write();
        test_backpressure();
        test_ar_before_aw();
        test_starvation();
        test_reset_mid_w();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
